game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 151 +++++++++++++++
 tb/tb_game_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: cursor / cell-write / run-pause-step controller for a cellular-automaton grid.
// Define GEN_COUNT_EN to build the saturating generation counter behind gen_count.
module game_ctrl #(
  parameter int unsigned GRID_N = 16,
  parameter int unsigned PERIOD = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        mark,
  input  logic        cell_val,
  input  logic        start,
  input  logic        pause,
  input  logic        step,
  input  logic        edit,
  output logic [7:0]  row_select,
  output logic [7:0]  col_select,
  output logic        set_initial,
  output logic        new_state,
  output logic        enable_update,
  output logic        running,
  output logic [15:0] gen_count
);

  localparam int unsigned    CW   = 8;
  localparam int unsigned    TW   = 26;
  localparam logic [CW-1:0]  CMAX = CW'(GRID_N - 1);
  localparam logic [TW-1:0]  TMAX = TW'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_SETUP  = 2'd0,
    S_WRITE  = 2'd1,
    S_RUN    = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_row, r_col, w_row_nxt, w_col_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic          r_set_initial, r_new_state, r_enable_update, r_running;
  logic          w_set_initial_nxt, w_new_state_nxt, w_enable_update_nxt, w_running_nxt;

  // One cursor axis: step down/up with wrap; opposing pulses cancel.
  function automatic logic [CW-1:0] move_axis(input logic [CW-1:0] v,
                                              input logic dec, input logic inc);
    if (dec && !inc)      return (v == '0)   ? CMAX : v - CW'(1);
    else if (inc && !dec) return (v == CMAX) ? '0   : v + CW'(1);
    else                  return v;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt         = r_state;
    w_row_nxt           = r_row;
    w_col_nxt           = r_col;
    w_tick_nxt          = r_tick;
    w_set_initial_nxt   = 1'b0;
    w_new_state_nxt     = 1'b0;
    w_enable_update_nxt = 1'b0;
    case (r_state)
      S_SETUP: begin
        if (mark) begin
          // cursor frozen so the write lands on the cell the user marked
          w_state_nxt       = S_WRITE;
          w_set_initial_nxt = 1'b1;
          w_new_state_nxt   = cell_val;
        end else begin
          w_row_nxt = move_axis(r_row, up, down);
          w_col_nxt = move_axis(r_col, left, right);
          if (start) begin
            w_state_nxt = S_RUN;
            w_tick_nxt  = '0;
          end
        end
      end
      S_WRITE: w_state_nxt = S_SETUP;
      S_RUN: begin
        if (edit) begin
          w_state_nxt = S_SETUP;
        end else if (pause) begin
          w_state_nxt = S_PAUSED;
        end else if (r_tick == TMAX) begin
          w_tick_nxt          = '0;
          w_enable_update_nxt = 1'b1;
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      S_PAUSED: begin
        if (edit)       w_state_nxt = S_SETUP;
        else if (start) w_state_nxt = S_RUN;
        else if (step)  w_enable_update_nxt = 1'b1;
      end
      default: w_state_nxt = S_SETUP;
    endcase
    w_running_nxt = (w_state_nxt == S_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_SETUP;
      r_row           <= '0;
      r_col           <= '0;
      r_tick          <= '0;
      r_set_initial   <= 1'b0;
      r_new_state     <= 1'b0;
      r_enable_update <= 1'b0;
      r_running       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_row           <= w_row_nxt;
      r_col           <= w_col_nxt;
      r_tick          <= w_tick_nxt;
      r_set_initial   <= w_set_initial_nxt;
      r_new_state     <= w_new_state_nxt;
      r_enable_update <= w_enable_update_nxt;
      r_running       <= w_running_nxt;
    end
  end

  assign row_select    = r_row;
  assign col_select    = r_col;
  assign set_initial   = r_set_initial;
  assign new_state     = r_new_state;
  assign enable_update = r_enable_update;
  assign running       = r_running;

`ifdef GEN_COUNT_EN
  logic [15:0] r_gen_count;
  logic        w_gen_clr;

  // Counts strobes in step with enable_update; restarts on each fresh run.
  assign w_gen_clr = (r_state == S_SETUP) && (w_state_nxt == S_RUN);

  always_ff @(posedge clk) begin
    if (reset || w_gen_clr)
      r_gen_count <= '0;
    else if (w_enable_update_nxt && (r_gen_count != 16'hFFFF))
      r_gen_count <= r_gen_count + 16'd1;
  end

  assign gen_count = r_gen_count;
`else
  assign gen_count = 16'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_game_ctrl;

  localparam int GRID_N = 16;
  localparam int PERIOD = 4;
  localparam int M_SETUP = 0, M_WRITE = 1, M_RUN = 2, M_PAUSED = 3;

  localparam logic [10:0] K_IDLE = 11'h000, K_UP = 11'h001, K_DN = 11'h002, K_LF = 11'h004,
                          K_RT = 11'h008, K_MK = 11'h010, K_CV = 11'h020, K_ST = 11'h040,
                          K_PA = 11'h080, K_SP = 11'h100, K_ED = 11'h200, K_RST = 11'h400;

`ifdef GEN_COUNT_EN
  localparam int GEN_ON = 1;
`else
  localparam int GEN_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic mark = 1'b0, cell_val = 1'b0, start = 1'b0, pause = 1'b0, step = 1'b0, edit = 1'b0;
  logic [7:0]  row_select, col_select;
  logic        set_initial, new_state, enable_update, running;
  logic [15:0] gen_count;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int   m_mode = M_SETUP, m_row = 0, m_col = 0, m_phase = 0, m_gen = 0;
  logic e_si = 1'b0, e_ns = 1'b0, e_en = 1'b0;

  game_ctrl #(.GRID_N(GRID_N), .PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .mark(mark), .cell_val(cell_val), .start(start), .pause(pause), .step(step), .edit(edit),
    .row_select(row_select), .col_select(col_select), .set_initial(set_initial),
    .new_state(new_state), .enable_update(enable_update), .running(running),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  // Model: m_phase counts run cycles since the last generation; a generation fires every PERIOD.
  task automatic model_step(input logic [10:0] c);
    e_si = 1'b0; e_ns = 1'b0; e_en = 1'b0;
    if (c[10]) begin
      m_mode = M_SETUP; m_row = 0; m_col = 0; m_phase = 0; m_gen = 0;
    end else begin
      case (m_mode)
        M_SETUP: begin
          if (c[4]) begin
            m_mode = M_WRITE; e_si = 1'b1; e_ns = c[5];
          end else begin
            m_row = (m_row + int'(c[1]) - int'(c[0]) + GRID_N) % GRID_N;
            m_col = (m_col + int'(c[3]) - int'(c[2]) + GRID_N) % GRID_N;
            if (c[6]) begin m_mode = M_RUN; m_phase = 0; m_gen = 0; end
          end
        end
        M_WRITE: m_mode = M_SETUP;
        M_RUN: begin
          if (c[9]) m_mode = M_SETUP;
          else if (c[7]) m_mode = M_PAUSED;
          else begin
            m_phase = m_phase + 1;
            if (m_phase == PERIOD) begin m_phase = 0; e_en = 1'b1; end
          end
        end
        default: begin
          if (c[9]) m_mode = M_SETUP;
          else if (c[6]) m_mode = M_RUN;
          else if (c[8]) e_en = 1'b1;
        end
      endcase
      if (GEN_ON == 1 && e_en && m_gen < 65535) m_gen = m_gen + 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input logic [10:0] c);
    up = c[0]; down = c[1]; left = c[2]; right = c[3]; mark = c[4]; cell_val = c[5];
    start = c[6]; pause = c[7]; step = c[8]; edit = c[9]; reset = c[10];
    model_step(c);
    @(posedge clk);
    #1;
    {up, down, left, right, mark, cell_val, start, pause, step, edit, reset} = '0;
  endtask

  task automatic test_reset();
    cyc(K_RST);
    checks++; if (row_select !== 8'd0) begin errors++; $display("FAIL reset_row got %0d want 0", row_select); end
    checks++; if (col_select !== 8'd0) begin errors++; $display("FAIL reset_col got %0d want 0", col_select); end
    checks++; if (set_initial !== 1'b0) begin errors++; $display("FAIL reset_set_initial got %b want 0", set_initial); end
    checks++; if (new_state !== 1'b0) begin errors++; $display("FAIL reset_new_state got %b want 0", new_state); end
    checks++; if (enable_update !== 1'b0) begin errors++; $display("FAIL reset_enable_update got %b want 0", enable_update); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count got %0d want 0", gen_count); end
  endtask

  task automatic test_cursor();
    cyc(K_RST);
    repeat (3) cyc(K_RT);
    repeat (2) cyc(K_DN);
    checks++; if (col_select !== 8'd3) begin errors++; $display("FAIL cursor_col got %0d want 3", col_select); end
    checks++; if (row_select !== 8'd2) begin errors++; $display("FAIL cursor_row got %0d want 2", row_select); end
    repeat (3) cyc(K_UP);
    checks++; if (row_select !== 8'(GRID_N - 1)) begin errors++; $display("FAIL cursor_row_wrap got %0d want %0d", row_select, GRID_N - 1); end
    cyc(K_UP | K_DN | K_LF | K_RT);
    checks++; if (row_select !== 8'(GRID_N - 1) || col_select !== 8'd3) begin
      errors++; $display("FAIL cursor_opposing got %0d,%0d want %0d,3", row_select, col_select, GRID_N - 1); end
    repeat (4) cyc(K_LF);
    checks++; if (col_select !== 8'(GRID_N - 1)) begin errors++; $display("FAIL cursor_col_wrap got %0d want %0d", col_select, GRID_N - 1); end
    cyc(K_DN);
    checks++; if (row_select !== 8'd0) begin errors++; $display("FAIL cursor_row_wrap_up got %0d want 0", row_select); end
  endtask

  task automatic test_write();
    cyc(K_RST);
    repeat (8) cyc(K_DN);
    repeat (7) cyc(K_RT);
    cyc(K_MK | K_CV);
    checks++; if (set_initial !== 1'b1 || new_state !== 1'b1) begin
      errors++; $display("FAIL write_strobe got si=%b ns=%b want 1,1", set_initial, new_state); end
    checks++; if (row_select !== 8'd8 || col_select !== 8'd7) begin
      errors++; $display("FAIL write_pos got %0d,%0d want 8,7", row_select, col_select); end
    checks++; if (enable_update !== 1'b0) begin errors++; $display("FAIL write_no_update got %b want 0", enable_update); end
    cyc(K_RT);
    checks++; if (set_initial !== 1'b0) begin errors++; $display("FAIL write_one_cycle got %b want 0", set_initial); end
    checks++; if (col_select !== 8'd7) begin errors++; $display("FAIL write_cursor_hold got %0d want 7", col_select); end
    cyc(K_RT);
    checks++; if (col_select !== 8'd8 || running !== 1'b0) begin
      errors++; $display("FAIL write_back_setup got col=%0d run=%b want 8,0", col_select, running); end
    cyc(K_MK);
    checks++; if (set_initial !== 1'b1 || new_state !== 1'b0) begin
      errors++; $display("FAIL write_zero got si=%b ns=%b want 1,0", set_initial, new_state); end
    cyc(K_IDLE);
  endtask

  task automatic test_run();
    cyc(K_RST);
    cyc(K_ST);
    checks++; if (running !== 1'b1 || enable_update !== 1'b0) begin
      errors++; $display("FAIL run_entry got run=%b en=%b want 1,0", running, enable_update); end
    for (int k = 1; k <= 13; k++) begin
      cyc((k == 6) ? (K_UP | K_MK) : K_IDLE);
      checks++; if (enable_update !== ((k % PERIOD) == 0)) begin
        errors++; $display("FAIL run_strobe cycle %0d got %b want %b", k, enable_update, (k % PERIOD) == 0); end
      checks++; if (running !== 1'b1 || set_initial !== 1'b0) begin
        errors++; $display("FAIL run_running cycle %0d got run=%b si=%b want 1,0", k, running, set_initial); end
    end
    checks++; if (gen_count !== 16'(3 * GEN_ON)) begin errors++; $display("FAIL run_gen_count got %0d want %0d", gen_count, 3 * GEN_ON); end
    checks++; if (row_select !== 8'd0) begin errors++; $display("FAIL run_cursor_ignored got %0d want 0", row_select); end
  endtask

  task automatic test_pause();
    cyc(K_RST);
    cyc(K_ST);
    repeat (PERIOD - 1) cyc(K_IDLE);
    cyc(K_PA);
    checks++; if (enable_update !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL pause_on_expiry got en=%b run=%b want 0,0", enable_update, running); end
    cyc(K_IDLE);
    checks++; if (enable_update !== 1'b0) begin errors++; $display("FAIL pause_hold got %b want 0", enable_update); end
    for (int s = 0; s < 2; s++) begin
      cyc(K_SP);
      checks++; if (enable_update !== 1'b1 || running !== 1'b0) begin
        errors++; $display("FAIL pause_step%0d got en=%b run=%b want 1,0", s, enable_update, running); end
      cyc(K_IDLE);
      checks++; if (enable_update !== 1'b0) begin errors++; $display("FAIL pause_step%0d_single got %b want 0", s, enable_update); end
    end
    cyc(K_ST);
    checks++; if (running !== 1'b1 || enable_update !== 1'b0) begin
      errors++; $display("FAIL pause_resume got run=%b en=%b want 1,0", running, enable_update); end
    cyc(K_IDLE);
    checks++; if (enable_update !== 1'b1) begin errors++; $display("FAIL pause_remaining got %b want 1", enable_update); end
    repeat (PERIOD - 1) cyc(K_IDLE);
    checks++; if (enable_update !== 1'b0) begin errors++; $display("FAIL pause_gap got %b want 0", enable_update); end
    cyc(K_IDLE);
    checks++; if (enable_update !== 1'b1) begin errors++; $display("FAIL pause_next_period got %b want 1", enable_update); end
    checks++; if (gen_count !== 16'(4 * GEN_ON)) begin errors++; $display("FAIL pause_gen_count got %0d want %0d", gen_count, 4 * GEN_ON); end
  endtask

  task automatic test_priority();
    cyc(K_RST);
    cyc(K_MK | K_CV | K_ST);
    checks++; if (set_initial !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL prio_mark_start got si=%b run=%b want 1,0", set_initial, running); end
    cyc(K_IDLE);
    checks++; if (running !== 1'b0 || set_initial !== 1'b0) begin
      errors++; $display("FAIL prio_no_run got run=%b si=%b want 0,0", running, set_initial); end
    cyc(K_ST);
    cyc(K_ED | K_PA);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL prio_edit_pause got %b want 0", running); end
    cyc(K_SP);
    checks++; if (enable_update !== 1'b0) begin errors++; $display("FAIL prio_step_in_setup got %b want 0", enable_update); end
    cyc(K_RT);
    checks++; if (col_select !== 8'd1) begin errors++; $display("FAIL prio_setup_after_edit got %0d want 1", col_select); end
    cyc(K_ST);
    cyc(K_PA);
    cyc(K_ED | K_ST | K_SP);
    checks++; if (running !== 1'b0 || enable_update !== 1'b0) begin
      errors++; $display("FAIL prio_paused_edit got run=%b en=%b want 0,0", running, enable_update); end
    cyc(K_RT);
    checks++; if (col_select !== 8'd2) begin errors++; $display("FAIL prio_paused_to_setup got %0d want 2", col_select); end
    cyc(K_ST);
    cyc(K_PA);
    cyc(K_ST | K_SP);
    checks++; if (running !== 1'b1 || enable_update !== 1'b0) begin
      errors++; $display("FAIL prio_start_over_step got run=%b en=%b want 1,0", running, enable_update); end
  endtask

  task automatic test_reset_mid();
    cyc(K_RST);
    cyc(K_RT);
    cyc(K_MK | K_CV);
    cyc(K_RST);
    checks++; if (set_initial !== 1'b0 || new_state !== 1'b0 || col_select !== 8'd0) begin
      errors++; $display("FAIL rst_mid_write got si=%b ns=%b col=%0d want 0,0,0", set_initial, new_state, col_select); end
    cyc(K_MK | K_CV | K_RST);
    checks++; if (set_initial !== 1'b0) begin errors++; $display("FAIL rst_with_mark got %b want 0", set_initial); end
    cyc(K_DN);
    cyc(K_ST);
    repeat (PERIOD - 1) cyc(K_IDLE);
    cyc(K_RST);
    checks++; if (enable_update !== 1'b0 || running !== 1'b0 || row_select !== 8'd0 || gen_count !== 16'd0) begin
      errors++; $display("FAIL rst_mid_run got en=%b run=%b row=%0d gen=%0d want 0,0,0,0",
                         enable_update, running, row_select, gen_count); end
    cyc(K_IDLE);
    checks++; if (running !== 1'b0 || enable_update !== 1'b0) begin
      errors++; $display("FAIL rst_stays_setup got run=%b en=%b want 0,0", running, enable_update); end
  endtask

  task automatic test_random();
    logic [10:0] c;
    cyc(K_RST);
    for (int n = 0; n < 3000; n++) begin
      c = '0;
      for (int b = 0; b < 7; b++) c[b] = ($urandom_range(0, 5) == 0);
      c[7]  = ($urandom_range(0, 15) == 0);
      c[8]  = ($urandom_range(0, 3) == 0);
      c[9]  = ($urandom_range(0, 39) == 0);
      c[10] = ($urandom_range(0, 299) == 0);
      cyc(c);
      checks++; if (row_select !== 8'(m_row) || col_select !== 8'(m_col)) begin
        errors++; $display("FAIL rand_cursor n=%0d got %0d,%0d want %0d,%0d", n, row_select, col_select, m_row, m_col); end
      checks++; if (set_initial !== e_si || (e_si && new_state !== e_ns)) begin
        errors++; $display("FAIL rand_write n=%0d got si=%b ns=%b want %b,%b", n, set_initial, new_state, e_si, e_ns); end
      checks++; if (enable_update !== e_en) begin
        errors++; $display("FAIL rand_update n=%0d got %b want %b", n, enable_update, e_en); end
      checks++; if (running !== (m_mode == M_RUN)) begin
        errors++; $display("FAIL rand_running n=%0d got %b want %b", n, running, m_mode == M_RUN); end
      checks++; if (gen_count !== 16'(m_gen)) begin
        errors++; $display("FAIL rand_gen n=%0d got %0d want %0d", n, gen_count, m_gen); end
      checks++; if (set_initial && enable_update) begin
        errors++; $display("FAIL rand_exclusive n=%0d got si=1 en=1 want not both", n); end
    end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_write();
    test_run();
    test_pause();
    test_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
